xor_array_pipe: RTL and testbench

- Parametrised, registered successor to the quad 2-input XOR gate block.
- Processes N-bit A/B operand pairs under a valid/ready handshake. Per beat it produces XOR or XNOR, or a running XOR accumulation over a frame terminated by a last marker.
- Sits between the board input pads (switch/register sources) and the output pad/LED drivers of the gate-lab designs.
- Adds backpressure, frame accumulation and beat counting, none of which the fixed quad gate has.

---
 rtl/xor_array_pipe.sv | 119 +++++++++++
 tb/tb_xor_array_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/xor_array_pipe.sv
// Registered XOR/XNOR/frame-accumulate array with valid/ready handshake.
// Optional feature: define XOR_ARRAY_POPCNT_EN to add the y_pop result popcount port.
module xor_array_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frm_len
`ifdef XOR_ARRAY_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] y_pop
`endif
);

  localparam logic [1:0]       MODE_XNOR = 2'b01;
  localparam logic [1:0]       MODE_ACC  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             is_acc;
  logic             accept;
  logic             produce;
  logic [WIDTH-1:0] ab;
  logic [WIDTH-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] result_len;

  assign in_ready = ~out_valid | out_ready;

  // clr zeroes the accumulator view seen by this very beat, so a clr'd last beat reports a 1-beat frame
  always_comb begin
    is_acc     = (mode == MODE_ACC);
    accept     = in_valid & in_ready;
    produce    = accept & (~is_acc | in_last);
    ab         = A ^ B;
    acc_base   = clr ? '0 : acc_q;
    cnt_base   = clr ? '0 : cnt_q;
    cnt_inc    = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_ONE;
    result     = ab;
    result_len = CNT_ONE;
    if (is_acc) begin
      result     = acc_base ^ ab;
      result_len = cnt_inc;
    end else if (mode == MODE_XNOR) begin
      result = ~ab;
    end
  end

  // Any non-accumulating accepted beat (XOR/XNOR or a frame end) closes the open frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      if (is_acc && !in_last) begin
        acc_q <= acc_q ^ ab;
        cnt_q <= cnt_inc;
      end else begin
        acc_q <= '0;
        cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y         <= '0;
      out_valid <= 1'b0;
      frm_len   <= '0;
    end else if (produce) begin
      Y         <= result;
      out_valid <= 1'b1;
      frm_len   <= result_len;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef XOR_ARRAY_POPCNT_EN
  localparam int POP_W = $clog2(WIDTH+1);

  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_pop <= '0;
    end else if (produce) begin
      y_pop <= popcount(result);
    end
  end
`endif

endmodule

// File: tb/tb_xor_array_pipe.sv
// Scoreboard bench for xor_array_pipe: directed beats push expected results, a monitor pops and compares.
// Also exercises the XOR_ARRAY_POPCNT_EN port when that macro is defined.
module tb_xor_array_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [1:0] mode;
  logic [3:0] A;
  logic [3:0] B;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [3:0] Y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] frm_len;
`ifdef XOR_ARRAY_POPCNT_EN
  logic [2:0] y_pop;
`endif

  typedef struct {
    logic [3:0] y;
    logic [7:0] len;
  } exp_t;

  exp_t sb[$];
  int   total_checks = 0;
  int   passed_checks = 0;

  xor_array_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .mode      (mode),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frm_len   (frm_len)
`ifdef XOR_ARRAY_POPCNT_EN
    ,
    .y_pop     (y_pop)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drives one beat and waits (bounded) for the handshake; called #1 after a rising edge
  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                               input logic last, input logic c, input logic exp_out,
                               input logic [3:0] exp_y, input logic [7:0] exp_len);
    logic got;
    exp_t e;
    mode = m; A = a; B = b; in_last = last; clr = c; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        if (exp_out) begin
          e.y = exp_y;
          e.len = exp_len;
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    clr = 1'b0;
    in_last = 1'b0;
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever out_valid & out_ready hold here
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", {28'd0, Y}, 32'hDEAD);
      end else begin
        e = sb.pop_front();
        checkOutput("Y", {28'd0, Y}, {28'd0, e.y});
        checkOutput("frm_len", {24'd0, frm_len}, {24'd0, e.len});
`ifdef XOR_ARRAY_POPCNT_EN
        checkOutput("y_pop", {29'd0, y_pop}, $countones(e.y));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; mode = 2'b00; A = 4'h0; B = 4'h0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_Y", {28'd0, Y}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_frm_len", {24'd0, frm_len}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(2'b00, 4'hC, 4'hA, 1'b0, 1'b0, 1'b1, 4'h6, 8'd1);
    applyStimulus(2'b01, 4'hF, 4'h5, 1'b0, 1'b0, 1'b1, 4'h5, 8'd1);
    applyStimulus(2'b01, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF, 8'd1);
    applyStimulus(2'b01, 4'h3, 4'h5, 1'b0, 1'b0, 1'b1, 4'h9, 8'd1);
    applyStimulus(2'b01, 4'hA, 4'h5, 1'b0, 1'b0, 1'b1, 4'h0, 8'd1);

    applyStimulus(2'b10, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
    applyStimulus(2'b10, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
    applyStimulus(2'b10, 4'h4, 4'h8, 1'b1, 1'b0, 1'b1, 4'hF, 8'd3);
    applyStimulus(2'b10, 4'h6, 4'h3, 1'b1, 1'b0, 1'b1, 4'h5, 8'd1);

    applyStimulus(2'b11, 4'h9, 4'h3, 1'b0, 1'b0, 1'b1, 4'hA, 8'd1);
    applyStimulus(2'b10, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
    applyStimulus(2'b00, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, 4'h0, 8'd1);
    applyStimulus(2'b10, 4'h2, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2, 8'd1);

    applyStimulus(2'b10, 4'h7, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
    applyStimulus(2'b10, 4'h9, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0);
    applyStimulus(2'b10, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3, 8'd1);

    for (int i = 0; i < 299; i++) begin
      applyStimulus(2'b10, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
    end
    applyStimulus(2'b10, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 8'd255);

    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(2'b00, 4'h1, 4'h2, 1'b0, 1'b0, 1'b1, 4'h3, 8'd1);
    fork
      applyStimulus(2'b00, 4'h5, 4'h5, 1'b0, 1'b0, 1'b1, 4'h0, 8'd1);
      begin
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
          checkOutput("stall_Y", {28'd0, Y}, 32'h3);
          checkOutput("stall_frm_len", {24'd0, frm_len}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(2'b00, 4'h6, 4'h0, 1'b0, 1'b0, 1'b1, 4'h6, 8'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    checkOutput("async_rst_Y", {28'd0, Y}, 32'd0);
    checkOutput("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_rst_frm_len", {24'd0, frm_len}, 32'd0);
`ifdef XOR_ARRAY_POPCNT_EN
    checkOutput("async_rst_y_pop", {29'd0, y_pop}, 32'd0);
`endif
    #1 rst = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    applyStimulus(2'b10, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(2'b10, 4'h5, 4'h0, 1'b1, 1'b0, 1'b1, 4'h5, 8'd1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
